// File: rtl/project_cache_pkg.sv
// Shared definitions for the project_cache tag-state model: command codes and
// address field widths.
package project_cache_pkg;

  typedef enum logic [3:0] {
    READ   = 4'd0,
    WRITE  = 4'd1,
    IFETCH = 4'd2,
    INVAL  = 4'd3,
    CLEAR  = 4'd8,
    PRINT  = 4'd9
  } cmd_e;

  localparam int ADDR_W      = 32;
  localparam int OFFSET_W    = 6;
  localparam int LINE_ADDR_W = ADDR_W - OFFSET_W;
  localparam int NUM_WAYS    = 2;

  function automatic int index_width(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_width(input int num_sets);
    return ADDR_W - OFFSET_W - $clog2(num_sets);
  endfunction

endpackage

// File: rtl/cache_set_lookup.sv
// Combinational tag compare and victim selection for one 2-way set.
module cache_set_lookup #(
  parameter int TAG_W = 20
) (
  input  logic [TAG_W-1:0] tag,
  input  logic [1:0]       set_valid,
  input  logic [TAG_W-1:0] way0_tag,
  input  logic [TAG_W-1:0] way1_tag,
  input  logic             set_lru,
  output logic             hit,
  output logic             hit_way,
  output logic             victim_way
);

  logic hit0;
  logic hit1;

  assign hit0    = set_valid[0] && (way0_tag == tag);
  assign hit1    = set_valid[1] && (way1_tag == tag);
  assign hit     = hit0 | hit1;
  // A set never holds the same tag twice, so hit1 alone identifies the way.
  assign hit_way = hit1;

  always_comb begin
    victim_way = set_lru;
    if (!set_valid[0]) begin
      victim_way = 1'b0;
    end else if (!set_valid[1]) begin
      victim_way = 1'b1;
    end
  end

endmodule

// File: rtl/project_cache.sv
// 2-way set-associative write-back/write-allocate cache state model: tracks
// tag/valid/dirty/LRU per set, access counters and the last memory line address.
module project_cache
  import project_cache_pkg::*;
#(
  parameter int NUM_SETS = 64
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic [3:0]             n,
  input  logic [ADDR_W-1:0]      add_in,
  input  logic                   done,
  output logic [LINE_ADDR_W-1:0] add_out
);

  localparam int IDX_W = index_width(NUM_SETS);
  localparam int TAG_W = tag_width(NUM_SETS);

  logic [NUM_SETS-1:0][1:0] valid_q;
  logic [NUM_SETS-1:0][1:0] dirty_q;
  // lru_q holds the index of the least recently used way of each set.
  logic [NUM_SETS-1:0]      lru_q;
  logic [TAG_W-1:0]         tag_mem [NUM_SETS][NUM_WAYS];

  logic [31:0] reads_cnt;
  logic [31:0] writes_cnt;
  logic [31:0] hits_cnt;
  logic [31:0] misses_cnt;

  cmd_e                   cmd;
  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic                   hit;
  logic                   hit_way;
  logic                   victim_way;
  logic                   acc_way;
  logic                   is_access;
  logic                   wb_needed;
  logic [LINE_ADDR_W-1:0] victim_line;
  logic                   unused_offset;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign cmd           = cmd_e'(n);
  assign idx           = add_in[OFFSET_W +: IDX_W];
  assign tag           = add_in[ADDR_W-1 -: TAG_W];
  assign unused_offset = ^add_in[OFFSET_W-1:0];
  assign is_access     = (cmd == READ) || (cmd == WRITE) || (cmd == IFETCH);

  cache_set_lookup #(
    .TAG_W(TAG_W)
  ) u_lookup (
    .tag        (tag),
    .set_valid  (valid_q[idx]),
    .way0_tag   (tag_mem[idx][0]),
    .way1_tag   (tag_mem[idx][1]),
    .set_lru    (lru_q[idx]),
    .hit        (hit),
    .hit_way    (hit_way),
    .victim_way (victim_way)
  );

  assign acc_way     = hit ? hit_way : victim_way;
  assign wb_needed   = valid_q[idx][victim_way] && dirty_q[idx][victim_way];
  assign victim_line = {tag_mem[idx][victim_way], idx};

  // Tags are meaningless while their valid bit is clear, so they need no reset.
  always_ff @(posedge clk) begin
    if (!done && is_access && !hit) begin
      tag_mem[idx][victim_way] <= tag;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      valid_q    <= '0;
      dirty_q    <= '0;
      lru_q      <= '0;
      reads_cnt  <= '0;
      writes_cnt <= '0;
      hits_cnt   <= '0;
      misses_cnt <= '0;
      add_out    <= '0;
    end else if (!done) begin
      case (cmd)
        READ, WRITE, IFETCH: begin
          if (cmd == WRITE) begin
            writes_cnt <= sat_inc(writes_cnt);
          end else begin
            reads_cnt <= sat_inc(reads_cnt);
          end
          if (hit) begin
            hits_cnt <= sat_inc(hits_cnt);
          end else begin
            misses_cnt <= sat_inc(misses_cnt);
            add_out    <= wb_needed ? victim_line : add_in[ADDR_W-1:OFFSET_W];
          end
          valid_q[idx][acc_way] <= 1'b1;
          if (cmd == WRITE) begin
            dirty_q[idx][acc_way] <= 1'b1;
          end else if (!hit) begin
            dirty_q[idx][acc_way] <= 1'b0;
          end
          lru_q[idx] <= ~acc_way;
        end
        INVAL: begin
          if (hit) begin
            valid_q[idx][hit_way] <= 1'b0;
            dirty_q[idx][hit_way] <= 1'b0;
          end
        end
        CLEAR: begin
          valid_q    <= '0;
          dirty_q    <= '0;
          lru_q      <= '0;
          reads_cnt  <= '0;
          writes_cnt <= '0;
          hits_cnt   <= '0;
          misses_cnt <= '0;
          add_out    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_project_cache.sv
// Self-checking bench for project_cache: directed vector table, corner-case
// sequences, and randomized traffic against a timestamp-LRU reference model.
`timescale 1ns/1ps
module tb_project_cache;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic [3:0]  n = 4'd9;
  logic [31:0] add_in = '0;
  logic        done = 1'b0;
  logic [25:0] add_out;

  int checks = 0;
  int errors = 0;

  project_cache #(.NUM_SETS(64)) dut (
    .clk     (clk),
    .clear   (clear),
    .n       (n),
    .add_in  (add_in),
    .done    (done),
    .add_out (add_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [25:0] exp_out;
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;
  } vec_t;

  vec_t vecs[14];

  // Reference model: per-way tag/valid/dirty plus an access timestamp for LRU.
  logic [19:0] mt [64][2];
  bit          mv [64][2];
  bit          md [64][2];
  longint      ms [64][2];
  longint      now;
  logic [25:0] m_out;
  logic [31:0] m_r, m_w, m_h, m_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [31:0] r, input logic [31:0] w,
                             input logic [31:0] h, input logic [31:0] m, input logic [25:0] o);
    check({name, " reads"},   dut.reads_cnt,  r);
    check({name, " writes"},  dut.writes_cnt, w);
    check({name, " hits"},    dut.hits_cnt,   h);
    check({name, " misses"},  dut.misses_cnt, m);
    check({name, " add_out"}, {6'd0, add_out}, {6'd0, o});
  endtask

  task automatic step(input logic [3:0] c, input logic [31:0] a);
    n = c;
    add_in = a;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    clear = 1'b0;
    #1;
    @(negedge clk);
    clear = 1'b1;
  endtask

  function automatic logic [31:0] msat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < 64; s++) begin
      for (int w = 0; w < 2; w++) begin
        mv[s][w] = 0;
        md[s][w] = 0;
        ms[s][w] = 0;
        mt[s][w] = '0;
      end
    end
    m_out = '0;
    m_r = 0; m_w = 0; m_h = 0; m_m = 0;
  endtask

  task automatic m_cmd(input logic [3:0] c, input logic [31:0] a);
    logic [5:0]  s;
    logic [19:0] t;
    int          w;
    s = a[11:6];
    t = a[31:12];
    w = -1;
    for (int i = 0; i < 2; i++) if (mv[s][i] && mt[s][i] == t) w = i;
    if (c <= 4'd2) begin
      now++;
      if (c == 4'd1) m_w = msat(m_w); else m_r = msat(m_r);
      if (w >= 0) begin
        m_h = msat(m_h);
      end else begin
        m_m = msat(m_m);
        if (!mv[s][0]) w = 0;
        else if (!mv[s][1]) w = 1;
        else w = (ms[s][0] < ms[s][1]) ? 0 : 1;
        m_out = (mv[s][w] && md[s][w]) ? {mt[s][w], s} : a[31:6];
        mv[s][w] = 1;
        md[s][w] = 0;
        mt[s][w] = t;
      end
      if (c == 4'd1) md[s][w] = 1;
      ms[s][w] = now;
    end else if (c == 4'd3) begin
      if (w >= 0) begin
        mv[s][w] = 0;
        md[s][w] = 0;
      end
    end else if (c == 4'd8) begin
      m_reset();
    end
  endtask

  initial begin
    vecs[0]  = '{4'd0, 32'h0000_1040, 26'h41, 0, 1};
    vecs[1]  = '{4'd0, 32'h0000_1040, 26'h41, 1, 1};
    vecs[2]  = '{4'd1, 32'h0000_0000, 26'h00, 1, 2};
    vecs[3]  = '{4'd0, 32'h0000_1000, 26'h40, 1, 3};
    vecs[4]  = '{4'd0, 32'h0000_2000, 26'h00, 1, 4};
    vecs[5]  = '{4'd0, 32'h0000_0080, 26'h02, 1, 5};
    vecs[6]  = '{4'd2, 32'h0000_1080, 26'h42, 1, 6};
    vecs[7]  = '{4'd0, 32'h0000_0080, 26'h42, 2, 6};
    vecs[8]  = '{4'd0, 32'h0000_2080, 26'h82, 2, 7};
    vecs[9]  = '{4'd0, 32'h0000_0080, 26'h82, 3, 7};
    vecs[10] = '{4'd0, 32'h0000_1080, 26'h42, 3, 8};
    vecs[11] = '{4'd1, 32'h0000_0080, 26'h42, 4, 8};
    vecs[12] = '{4'd0, 32'h0000_2080, 26'h82, 4, 9};
    vecs[13] = '{4'd0, 32'h0000_3080, 26'h02, 4, 10};

    #2;
    clear = 1'b0;
    #1;
    check_state("reset", 0, 0, 0, 0, 26'h0);
    @(negedge clk);
    clear = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].cmd, vecs[i].addr);
      check($sformatf("vec%0d add_out", i), {6'd0, add_out}, {6'd0, vecs[i].exp_out});
      check($sformatf("vec%0d hits", i), dut.hits_cnt, vecs[i].exp_hits);
      check($sformatf("vec%0d misses", i), dut.misses_cnt, vecs[i].exp_misses);
    end
    check("vec writes", dut.writes_cnt, 2);
    check("vec reads", dut.reads_cnt, 12);

    // Invalidate then re-read the same line.
    pulse_reset();
    step(4'd0, 32'hA000_0000);
    step(4'd3, 32'hA000_0000);
    check_state("inval", 1, 0, 0, 1, 26'h280_0000);
    step(4'd3, 32'hB000_0000);
    step(4'd0, 32'hA000_0000);
    check_state("reread", 2, 0, 0, 2, 26'h280_0000);

    // Clear command, then every old line misses.
    step(4'd1, 32'h0000_1040);
    step(4'd0, 32'h0000_2080);
    step(4'd8, 32'h0000_0000);
    check_state("cmdclear", 0, 0, 0, 0, 26'h0);
    step(4'd0, 32'h0000_1040);
    step(4'd0, 32'hA000_0000);
    check_state("after_clear", 2, 0, 0, 2, 26'h280_0000);

    // Asynchronous clear mid-trace, with a command held across release.
    step(4'd0, 32'h0000_2080);
    #2;
    clear = 1'b0;
    n = 4'd0;
    add_in = 32'h0000_1040;
    #1;
    check_state("async", 0, 0, 0, 0, 26'h0);
    @(negedge clk);
    clear = 1'b1;
    #1;
    check("release misses", dut.misses_cnt, 0);
    @(posedge clk);
    #1;
    check_state("first_edge", 1, 0, 0, 1, 26'h41);

    // done freezes everything, including a clear command.
    done = 1'b1;
    step(4'd0, 32'h5555_0000);
    step(4'd1, 32'h6666_0040);
    step(4'd8, 32'h0000_0000);
    check_state("done", 1, 0, 0, 1, 26'h41);
    done = 1'b0;
    step(4'd9, 32'h0000_1040);
    step(4'd5, 32'h0000_1040);
    check_state("noop", 1, 0, 0, 1, 26'h41);

    // Randomized traffic against the reference model.
    pulse_reset();
    m_reset();
    now = 0;
    for (int k = 0; k < 600; k++) begin
      int unsigned r;
      logic [3:0]  c;
      logic [19:0] t;
      logic [5:0]  s;
      logic [5:0]  off;
      logic        d;
      r = $urandom_range(0, 99);
      if (r < 30) c = 4'd0;
      else if (r < 55) c = 4'd1;
      else if (r < 70) c = 4'd2;
      else if (r < 82) c = 4'd3;
      else if (r < 84) c = 4'd8;
      else if (r < 90) c = 4'd9;
      else c = 4'($urandom_range(10, 15));
      t = ($urandom_range(0, 7) == 0) ? 20'($urandom) : 20'($urandom_range(0, 3));
      s = 6'($urandom_range(0, 3));
      off = 6'($urandom);
      d = ($urandom_range(0, 9) == 0);
      done = d;
      n = c;
      add_in = {t, s, off};
      @(posedge clk);
      if (!d) m_cmd(c, {t, s, off});
      #1;
      check_state($sformatf("rand%0d", k), m_r, m_w, m_h, m_m, m_out);
    end
    done = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
